// File: rtl/lms_ctr_spi_slave.sv
// lms_ctr_spi_slave
// SPI mode-0 slave (MSB first) with an 8-bit-data CPU register port. It is the
// responder to the lms_ctr SPI master and shares the master's register map.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   SCLK, MOSI, SS_n      SPI pins from the external master (asynchronous)
//   MISO, MISO_oe         SPI data back to the master and its output enable
//   spi_select, mem_addr  register-port select and 3-bit address
//   read_n, write_n       active-low CPU strobes
//   data_from_cpu         16-bit write data
//   data_to_cpu           16-bit registered read data
//   irq                   registered interrupt
//   dataavailable         RRDY
//   readyfordata          TRDY
//   endofpacket           EOP
`timescale 1ns/1ps
module lms_ctr_spi_slave #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket
);
    localparam int CW = $clog2(DATABITS);

    // Pin synchronisers, history flops and registered edge pulses
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
    logic                   r_sclk_d, r_mosi_d, r_ss_d;
    logic                   r_rise, r_fall, r_ss_fall, r_ss_rise;
    logic                   w_sclk_s, w_mosi_s, w_ss_s, w_active;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    // Pulses are one clk behind the synchronised pins, so qualify them with
    // the history copy of SS_n that is aligned with them.
    assign w_active = ~r_ss_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_mosi_d    <= 1'b0;
            r_ss_d      <= 1'b1;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_ss_rise   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_d    <= w_sclk_s;
            // MOSI history lines up with the cycle the rise pulse is raised
            r_mosi_d    <= w_mosi_s;
            r_ss_d      <= w_ss_s;
            r_rise      <= w_sclk_s & ~r_sclk_d;
            r_fall      <= ~w_sclk_s & r_sclk_d;
            r_ss_fall   <= r_ss_d & ~w_ss_s;
            r_ss_rise   <= ~r_ss_d & w_ss_s;
        end
    end

    // CPU access strobes: one clk wide, re-armed only after they drop
    logic        r_wr_stb, r_rd_stb;
    logic [2:0]  r_wr_addr, r_rd_addr;
    logic [15:0] r_wdata;
    logic        w_wr_start, w_rd_start;

    assign w_wr_start = spi_select & ~write_n & ~r_wr_stb;
    assign w_rd_start = spi_select & ~read_n & ~r_rd_stb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_wdata   <= '0;
        end else begin
            r_wr_stb <= w_wr_start;
            r_rd_stb <= w_rd_start;
            if (w_wr_start) begin
                r_wr_addr <= mem_addr;
                r_wdata   <= data_from_cpu;
            end
            if (w_rd_start)
                r_rd_addr <= mem_addr;
        end
    end

    // SPI datapath and status
    logic [DATABITS-1:0] r_rx_shift, r_rx_holding, r_tx_shift, r_tx_holding, r_eop_val;
    logic [CW-1:0]       r_bitcnt;
    logic                r_byte_done, r_tx_primed, r_pend_ur;
    logic                r_rrdy, r_roe, r_toe, r_tur, r_eop;
    logic [15:0]         r_ctrl;
    logic [DATABITS-1:0] w_rx_byte;
    logic                w_wr_tx, w_wr_st, w_wr_ctl, w_wr_eop, w_rd_rx;
    logic                w_tx_accept, w_load, w_tur_set, w_byte_cmp, w_bit_last;
    logic                w_trdy, w_tmt, w_e;
    logic [15:0]         w_status, w_rd_mux;

    assign w_wr_tx  = r_wr_stb & (r_wr_addr == 3'd1);
    assign w_wr_st  = r_wr_stb & (r_wr_addr == 3'd2);
    assign w_wr_ctl = r_wr_stb & (r_wr_addr == 3'd3);
    assign w_wr_eop = r_wr_stb & (r_wr_addr == 3'd6);
    assign w_rd_rx  = r_rd_stb & ((r_rd_addr == 3'd0) | (r_rd_addr == 3'd7));

    assign w_tx_accept = w_wr_tx & ~r_tx_primed;
    assign w_bit_last  = (r_bitcnt == CW'(DATABITS-1));
    assign w_rx_byte   = {r_rx_shift[DATABITS-2:0], r_mosi_d};
    // SS_n edges take priority over SCLK pulses landing in the same clk
    assign w_load     = ~r_ss_rise & (r_ss_fall |
                        (w_active & r_fall & (r_bitcnt == '0) & r_byte_done));
    assign w_tur_set  = ~r_ss_rise & ~r_ss_fall & w_active & r_rise & r_pend_ur;
    assign w_byte_cmp = ~r_ss_rise & ~r_ss_fall & w_active & r_rise & w_bit_last;

    assign w_trdy   = ~r_tx_primed;
    assign w_tmt    = ~r_tx_primed & w_ss_s;
    assign w_e      = r_roe | r_toe | r_tur;
    assign w_status = {6'b0, r_eop, w_e, r_rrdy, w_trdy, w_tmt, r_toe, r_roe, r_tur, 2'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_shift   <= '0;
            r_rx_holding <= '0;
            r_tx_shift   <= '0;
            r_tx_holding <= '0;
            r_eop_val    <= '0;
            r_bitcnt     <= '0;
            r_byte_done  <= 1'b0;
            r_tx_primed  <= 1'b0;
            r_pend_ur    <= 1'b0;
            r_rrdy       <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
            r_tur        <= 1'b0;
            r_eop        <= 1'b0;
            r_ctrl       <= '0;
        end else begin
            if (r_ss_rise) begin
                // Partial byte is dropped; no RRDY
                r_bitcnt    <= '0;
                r_byte_done <= 1'b0;
            end else if (r_ss_fall) begin
                r_bitcnt    <= '0;
                r_byte_done <= 1'b0;
            end else if (w_active) begin
                if (r_rise) begin
                    r_rx_shift  <= w_rx_byte;
                    r_bitcnt    <= w_bit_last ? '0 : r_bitcnt + CW'(1);
                    r_byte_done <= w_bit_last;
                end
                if (r_fall) begin
                    if (w_load)
                        r_byte_done <= 1'b0;
                    else
                        r_tx_shift <= {r_tx_shift[DATABITS-2:0], 1'b0};
                end
            end

            // Underrun is only flagged once the master clocks the empty byte
            if (r_ss_rise)
                r_pend_ur <= 1'b0;
            else if (w_load && !r_tx_primed)
                r_pend_ur <= 1'b1;
            else if (w_tur_set)
                r_pend_ur <= 1'b0;

            if (w_load) begin
                r_tx_shift <= r_tx_primed ? r_tx_holding : '0;
                if (r_tx_primed)
                    r_tx_primed <= 1'b0;
            end
            if (w_tx_accept) begin
                r_tx_holding <= r_wdata[DATABITS-1:0];
                r_tx_primed  <= 1'b1;
            end

            if (w_byte_cmp)
                r_rx_holding <= w_rx_byte;

            if (w_byte_cmp)
                r_rrdy <= 1'b1;
            else if (w_wr_st || w_rd_rx)
                r_rrdy <= 1'b0;

            if (w_wr_st)
                r_roe <= 1'b0;
            else if (w_byte_cmp && r_rrdy)
                r_roe <= 1'b1;

            if (w_wr_st)
                r_toe <= 1'b0;
            else if (w_wr_tx && r_tx_primed)
                r_toe <= 1'b1;

            if (w_wr_st)
                r_tur <= 1'b0;
            else if (w_tur_set)
                r_tur <= 1'b1;

            if (w_wr_st)
                r_eop <= 1'b0;
            else if ((w_byte_cmp && (w_rx_byte == r_eop_val)) ||
                     (w_wr_tx && (r_wdata[DATABITS-1:0] == r_eop_val)))
                r_eop <= 1'b1;

            if (w_wr_ctl)
                r_ctrl <= r_wdata & 16'h03DC;
            if (w_wr_eop)
                r_eop_val <= r_wdata[DATABITS-1:0];
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (mem_addr)
            3'd0, 3'd7: w_rd_mux = {{(16-DATABITS){1'b0}}, r_rx_holding};
            3'd2:       w_rd_mux = w_status;
            3'd3:       w_rd_mux = r_ctrl;
            3'd6:       w_rd_mux = {{(16-DATABITS){1'b0}}, r_eop_val};
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (w_rd_start)
                data_to_cpu <= w_rd_mux;
            irq <= (r_eop & r_ctrl[9]) | (w_e & r_ctrl[8]) | (r_rrdy & r_ctrl[7]) |
                   (w_trdy & r_ctrl[6]) | (r_toe & r_ctrl[4]) | (r_roe & r_ctrl[3]) |
                   (r_tur & r_ctrl[2]);
        end
    end

    assign MISO          = r_tx_shift[DATABITS-1];
    assign MISO_oe       = ~w_ss_s;
    assign dataavailable = r_rrdy;
    assign readyfordata  = w_trdy;
    assign endofpacket   = r_eop;

endmodule

// File: tb/tb_lms_ctr_spi_slave.sv
`timescale 1ns/1ps
module tb_lms_ctr_spi_slave;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SS_n = 1'b1;
    logic        MISO, MISO_oe;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0;
    logic [15:0] data_to_cpu;
    logic        irq, dataavailable, readyfordata, endofpacket;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] rd_q[$];
    string       rd_nm[$];
    logic [7:0]  miso_q[$];

    lms_ctr_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
        .dataavailable(dataavailable), .readyfordata(readyfordata),
        .endofpacket(endofpacket)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    // Read monitor: a read access starts at the posedge after read_n falls;
    // data_to_cpu is checked on the following negedge.
    initial begin : rd_mon
        forever begin
            @(negedge read_n);
            @(posedge clk);
            @(negedge clk);
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: got 0x%04h with no expectation", data_to_cpu);
            end else begin
                chk(rd_nm.pop_front(), data_to_cpu, rd_q.pop_front());
            end
        end
    end

    // MISO monitor: sample MISO as the master does, on SCLK rising; whole
    // bytes are compared, partial bytes are dropped when SS_n rises.
    initial begin : miso_mon
        logic [7:0] bits;
        int         n;
        forever begin
            @(negedge SS_n);
            bits = 8'h00;
            n = 0;
            while (!SS_n) begin
                @(posedge SCLK or posedge SS_n);
                if (SS_n) break;
                bits = {bits[6:0], MISO};
                n++;
                if (n == 8) begin
                    if (miso_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL miso_unexpected: got 0x%02h with no expectation", bits);
                    end else begin
                        chk("miso_byte", {8'h00, bits}, {8'h00, miso_q.pop_front()});
                    end
                    n = 0;
                end
            end
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
        rd_q.push_back(exp);
        rd_nm.push_back(nm);
        @(negedge clk);
        spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic ss_low();
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Master clocks the top n bits of b at clk/10
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = b[i];
            repeat (5) @(negedge clk);
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"}, {15'h0, MISO}, 16'h0);
        chk({tag, "_miso_oe"}, {15'h0, MISO_oe}, 16'h0);
        chk({tag, "_data_to_cpu"}, data_to_cpu, 16'h0);
        chk({tag, "_irq"}, {15'h0, irq}, 16'h0);
        chk({tag, "_dataavailable"}, {15'h0, dataavailable}, 16'h0);
        chk({tag, "_readyfordata"}, {15'h0, readyfordata}, 16'h1);
        chk({tag, "_endofpacket"}, {15'h0, endofpacket}, 16'h0);
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (5) @(negedge clk);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        cpu_read(3'd2, 16'h0060, "status_after_reset");

        // Control readback mask and TRDY interrupt
        cpu_write(3'd3, 16'hFFFF);
        cpu_read(3'd3, 16'h03DC, "ctrl_mask");
        chk("irq_trdy", {15'h0, irq}, 16'h1);
        cpu_write(3'd3, 16'h0000);
        repeat (2) @(negedge clk);
        chk("irq_ctrl_off", {15'h0, irq}, 16'h0);

        // Basic transfer: tx 0xA5, rx 0x3C
        cpu_write(3'd1, 16'h00A5);
        chk("trdy_after_txwr", {15'h0, readyfordata}, 16'h0);
        miso_q.push_back(8'hA5);
        ss_low();
        chk("miso_oe_active", {15'h0, MISO_oe}, 16'h1);
        spi_bits(8'h3C, 8);
        ss_high();
        chk("basic_rrdy", {15'h0, dataavailable}, 16'h1);
        cpu_read(3'd0, 16'h003C, "basic_rx");
        cpu_read(3'd2, 16'h0060, "basic_status");

        // Overrun with iROE
        cpu_write(3'd3, 16'h0008);
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h00);
        ss_low();
        spi_bits(8'h11, 8);
        repeat (8) @(negedge clk);
        chk("ovr_irq_first", {15'h0, irq}, 16'h0);
        spi_bits(8'h22, 8);
        ss_high();
        chk("ovr_irq", {15'h0, irq}, 16'h1);
        cpu_read(3'd0, 16'h0022, "ovr_rx");
        cpu_read(3'd2, 16'h016C, "ovr_status");
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, 16'h0060, "ovr_status_cleared");
        chk("ovr_irq_cleared", {15'h0, irq}, 16'h0);
        cpu_write(3'd3, 16'h0000);

        // Underrun, then SS_n pulse with no clocks gives no further TUR
        miso_q.push_back(8'h00);
        ss_low();
        spi_bits(8'h5A, 8);
        ss_high();
        cpu_read(3'd2, 16'h01E4, "ur_status");
        cpu_read(3'd7, 16'h005A, "ur_rx_addr7");
        cpu_write(3'd2, 16'h0000);
        ss_low();
        ss_high();
        cpu_read(3'd2, 16'h0060, "ur_no_extra_tur");

        // TOE and TRDY
        cpu_write(3'd1, 16'h0001);
        cpu_write(3'd1, 16'h0002);
        cpu_read(3'd2, 16'h0110, "toe_status");
        miso_q.push_back(8'h01);
        ss_low();
        chk("trdy_after_load", {15'h0, readyfordata}, 16'h1);
        spi_bits(8'hC3, 8);
        ss_high();
        cpu_read(3'd0, 16'h00C3, "toe_rx");
        cpu_read(3'd2, 16'h0170, "toe_status_after");
        cpu_write(3'd2, 16'h0000);

        // Abort after 5 bits, then aligned EOP byte
        ss_low();
        spi_bits(8'hFF, 5);
        ss_high();
        chk("abort_rrdy", {15'h0, dataavailable}, 16'h0);
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd6, 16'h007E);
        cpu_read(3'd6, 16'h007E, "eop_value");
        cpu_write(3'd1, 16'h0033);
        miso_q.push_back(8'h33);
        ss_low();
        spi_bits(8'h7E, 8);
        ss_high();
        chk("eop_rrdy", {15'h0, dataavailable}, 16'h1);
        chk("eop_pin", {15'h0, endofpacket}, 16'h1);
        cpu_read(3'd0, 16'h007E, "eop_rx_aligned");
        cpu_read(3'd2, 16'h0260, "eop_status");
        cpu_write(3'd2, 16'h0000);
        chk("eop_cleared", {15'h0, endofpacket}, 16'h0);
        cpu_write(3'd1, 16'h007E);
        chk("eop_from_txwr", {15'h0, endofpacket}, 16'h1);

        // Reset in the middle of a byte
        ss_low();
        spi_bits(8'hF0, 4);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("midrst");
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cpu_write(3'd1, 16'h0096);
        miso_q.push_back(8'h96);
        ss_low();
        spi_bits(8'h69, 8);
        ss_high();
        cpu_read(3'd0, 16'h0069, "post_rst_rx");
        cpu_read(3'd2, 16'h0060, "post_rst_status");

        repeat (10) @(negedge clk);
        chk("rd_queue_empty", 16'(rd_q.size()), 16'h0);
        chk("miso_queue_empty", 16'(miso_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
